// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch and
//   the load/store data path. One access is in flight at a time; each grant
//   runs IDLE -> ISSUE -> (WAIT) -> RESP and returns to IDLE. Read data is
//   routed back to whichever requester was granted, and stall holds the PC /
//   regfile write while anything is outstanding.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_valid) and address
//   if_rdata/if_valid   fetched word and its one-cycle completion pulse
//   d_req/d_we          data request (held until d_done), 1 = store
//   d_addr/d_wdata      data address and store data
//   d_rdata/d_done      load data and one-cycle completion pulse
//   mem_en/mem_we       memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata  memory address and write data, latched at grant
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   stall               combinational pipeline hold
//
// Parameters
//   ADDR_W, DATA_W      address / data widths
//   MEM_LAT             cycles from the mem_en cycle to valid mem_rdata (1..8)

module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  // Counter holds at most MEM_LAT-1 = 7.
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam bit MULTI_CYCLE = (MEM_LAT > 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // last_grant_q doubles as the grant id of the access in flight:
  // it is written only at a grant, so during ISSUE/WAIT/RESP it names the
  // current owner, and back in IDLE it names the previous one.
  logic             last_grant_q, last_grant_d;   // 1 = data, 0 = fetch
  logic             store_q, store_d;             // in-flight access is a store
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
  logic              if_valid_d, d_done_d;

  logic grant_c;
  logic grant_data_c;

  // Arbitration: data first, except fetch wins right after a data grant.
  // Blocked while a response pulses so a still-held request is not re-granted.
  always_comb begin
    grant_c      = (if_req | d_req) & ~if_valid & ~d_done;
    grant_data_c = d_req & ~(if_req & last_grant_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_c) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = MULTI_CYCLE ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        // Counter reads 0 in the RESP cycle, so leave when it is about to.
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    if_rdata_d   = if_rdata;
    d_rdata_d    = d_rdata;
    if_valid_d   = 1'b0;
    d_done_d     = 1'b0;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          // mem_en is registered, so setting it here makes it high in ISSUE.
          mem_en_d     = 1'b1;
          last_grant_d = grant_data_c;
          if (grant_data_c) begin
            mem_we_d    = d_we;
            store_d     = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            store_d    = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_LOAD;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        // mem_rdata is valid this cycle; the pulse follows one cycle later.
        if (last_grant_q) begin
          d_done_d = 1'b1;
          if (!store_q) d_rdata_d = mem_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_valid     <= 1'b0;
      d_done       <= 1'b0;
      last_grant_q <= 1'b0;
      store_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mem_en       <= mem_en_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      if_rdata     <= if_rdata_d;
      d_rdata      <= d_rdata_d;
      if_valid     <= if_valid_d;
      d_done       <= d_done_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
      cnt_q        <= cnt_d;
    end
  end

  // Hold while busy, or while a request waits that is not completing now.
  assign stall = (state_q != ST_IDLE) | ((if_req | d_req) & ~if_valid & ~d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Four DUT lanes with MEM_LAT = 1..4,
// each with its own latency-accurate memory model; expected response data is
// queued when a request is driven and popped when the DUT pulses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned NL = 4;
  localparam logic [31:0] POISON = 32'hBAD0_BAD0;
  localparam logic [31:0] F_ADDR = 32'h0040_0000;
  localparam logic [31:0] L_ADDR = 32'h1001_0000;
  localparam logic [31:0] S_ADDR = 32'h1001_0004;
  localparam logic [31:0] A_ADDR = 32'h0040_0100;
  localparam logic [31:0] B_ADDR = 32'h0040_0200;
  localparam logic [31:0] F_DATA = 32'h3C01_0040;
  localparam logic [31:0] L_DATA = 32'h0000_0042;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req    [NL];
  logic [31:0] if_addr   [NL];
  logic [31:0] if_rdata  [NL];
  logic        if_valid  [NL];
  logic        d_req     [NL];
  logic        d_we      [NL];
  logic [31:0] d_addr    [NL];
  logic [31:0] d_wdata   [NL];
  logic [31:0] d_rdata   [NL];
  logic        d_done    [NL];
  logic        mem_en    [NL];
  logic        mem_we    [NL];
  logic [31:0] mem_addr  [NL];
  logic [31:0] mem_wdata [NL];
  logic [31:0] mem_rdata [NL];
  logic        stall     [NL];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] last_fetch;
  logic [31:0] last_load;

  always #5 clk = ~clk;

  // Read-only memory contents.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      F_ADDR:  return F_DATA;
      L_ADDR:  return L_DATA;
      default: return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [32:0] rd_pipe [8];

    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_valid (if_valid[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_done   (d_done[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stall    (stall[g])
    );

    // Read data appears exactly g+1 cycles after the mem_en cycle; poison otherwise.
    always_ff @(posedge clk) begin
      rd_pipe[0] <= {mem_en[g] & ~mem_we[g], mem_fn(mem_addr[g])};
      for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata[g] = rd_pipe[g][32] ? rd_pipe[g][31:0] : POISON;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    check({tag, "_queued"}, 32'(sb.size() != 0), 32'd1);
    e = POISON;
    if (sb.size() != 0) e = sb.pop_front();
    check(tag, obs, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; if_addr[l] = '0; d_req[l] = 1'b0;
      d_we[l] = 1'b0; d_addr[l] = '0; d_wdata[l] = '0;
    end
    last_fetch = '0;
    last_load  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on every lane.
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("rst_mem_en_l%0d", l),    32'(mem_en[l]),   32'd0);
      check($sformatf("rst_mem_we_l%0d", l),    32'(mem_we[l]),   32'd0);
      check($sformatf("rst_mem_addr_l%0d", l),  mem_addr[l],      32'd0);
      check($sformatf("rst_mem_wdata_l%0d", l), mem_wdata[l],     32'd0);
      check($sformatf("rst_if_rdata_l%0d", l),  if_rdata[l],      32'd0);
      check($sformatf("rst_if_valid_l%0d", l),  32'(if_valid[l]), 32'd0);
      check($sformatf("rst_d_rdata_l%0d", l),   d_rdata[l],       32'd0);
      check($sformatf("rst_d_done_l%0d", l),    32'(d_done[l]),   32'd0);
      check($sformatf("rst_stall_l%0d", l),     32'(stall[l]),    32'd0);
    end
    cyc();

    // Fetch alone, MEM_LAT=1; if_req still high in the if_valid cycle.
    if_req[0] = 1'b1; if_addr[0] = F_ADDR; sb.push_back(F_DATA);
    for (int c = 0; c < 7; c++) begin
      if (c == 4) if_req[0] = 1'b0;
      @(negedge clk);
      check($sformatf("fetch_mem_en_c%0d", c),   32'(mem_en[0]),   32'(c == 1));
      check($sformatf("fetch_if_valid_c%0d", c), 32'(if_valid[0]), 32'(c == 3));
      check($sformatf("fetch_stall_c%0d", c),    32'(stall[0]),    32'(c <= 2));
      if (mem_en[0]) begin
        check("fetch_mem_addr", mem_addr[0], F_ADDR);
        check("fetch_mem_we", 32'(mem_we[0]), 32'd0);
      end
      if (if_valid[0]) pop_check("fetch_rdata", if_rdata[0]);
      cyc();
    end

    // Store, MEM_LAT=3; address/data changed after the grant must be ignored.
    d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = S_ADDR; d_wdata[2] = 32'hDEAD_BEEF;
    sb.push_back(32'h0);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin d_addr[2] = 32'hFFFF_FFF0; d_wdata[2] = 32'h1234_5678; end
      if (c == 6) begin d_req[2] = 1'b0; d_we[2] = 1'b0; end
      @(negedge clk);
      check($sformatf("store_mem_en_c%0d", c), 32'(mem_en[2]), 32'(c == 1));
      check($sformatf("store_d_done_c%0d", c), 32'(d_done[2]), 32'(c == 5));
      check($sformatf("store_stall_c%0d", c),  32'(stall[2]),  32'(c <= 4));
      if (mem_en[2]) begin
        check("store_mem_we", 32'(mem_we[2]), 32'd1);
        check("store_mem_addr", mem_addr[2], S_ADDR);
        check("store_mem_wdata", mem_wdata[2], 32'hDEAD_BEEF);
      end
      if (d_done[2]) pop_check("store_d_rdata", d_rdata[2]);
      cyc();
    end

    // Contention from reset, MEM_LAT=2: grants D, I, D, I, 5 cycles apart.
    rst = 1'b1;
    if_req[1] = 1'b1; if_addr[1] = F_ADDR;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = L_ADDR;
    cyc();
    cyc();
    rst = 1'b0;
    sb.push_back(L_DATA); sb.push_back(F_DATA); sb.push_back(L_DATA); sb.push_back(F_DATA);
    for (int c = 0; c < 22; c++) begin
      if (c == 20) begin if_req[1] = 1'b0; d_req[1] = 1'b0; end
      @(negedge clk);
      check($sformatf("cont_mem_en_c%0d", c), 32'(mem_en[1]), 32'(c < 20 && c % 5 == 1));
      check($sformatf("cont_d_done_c%0d", c), 32'(d_done[1]),
            32'(c < 20 && c % 5 == 4 && (c / 5) % 2 == 0));
      check($sformatf("cont_if_valid_c%0d", c), 32'(if_valid[1]),
            32'(c < 20 && c % 5 == 4 && (c / 5) % 2 == 1));
      check($sformatf("cont_stall_c%0d", c), 32'(stall[1]), 32'(c < 20 && c % 5 != 4));
      if (mem_en[1])
        check($sformatf("cont_mem_addr_c%0d", c), mem_addr[1],
              ((c / 5) % 2 == 0) ? L_ADDR : F_ADDR);
      if (d_done[1]) begin
        check($sformatf("cont_if_rdata_kept_c%0d", c), if_rdata[1], last_fetch);
        pop_check($sformatf("cont_d_rdata_c%0d", c), d_rdata[1]);
        last_load = L_DATA;
      end
      if (if_valid[1]) begin
        check($sformatf("cont_d_rdata_kept_c%0d", c), d_rdata[1], last_load);
        pop_check($sformatf("cont_if_rdata_c%0d", c), if_rdata[1]);
        last_fetch = F_DATA;
      end
      cyc();
    end

    // Abort, MEM_LAT=4: reset during WAIT discards the in-flight fetch.
    if_req[3] = 1'b1; if_addr[3] = A_ADDR;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin rst = 1'b1; if_req[3] = 1'b0; end
      @(negedge clk);
      check($sformatf("abort_mem_en_c%0d", c), 32'(mem_en[3]), 32'(c == 1));
      check($sformatf("abort_stall_c%0d", c),  32'(stall[3]),  32'd1);
      cyc();
    end
    rst = 1'b0;
    for (int c = 4; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("abort_mem_en_c%0d", c),   32'(mem_en[3]),   32'd0);
      check($sformatf("abort_if_valid_c%0d", c), 32'(if_valid[3]), 32'd0);
      check($sformatf("abort_d_done_c%0d", c),   32'(d_done[3]),   32'd0);
      check($sformatf("abort_stall_c%0d", c),    32'(stall[3]),    32'd0);
      check($sformatf("abort_mem_addr_c%0d", c), mem_addr[3],      32'd0);
      check($sformatf("abort_if_rdata_c%0d", c), if_rdata[3],      32'd0);
      cyc();
    end

    // Fresh fetch after the abort starts cleanly from IDLE.
    if_req[3] = 1'b1; if_addr[3] = B_ADDR; sb.push_back(mem_fn(B_ADDR));
    for (int c = 0; c < 9; c++) begin
      if (c == 7) if_req[3] = 1'b0;
      @(negedge clk);
      check($sformatf("post_mem_en_c%0d", c),   32'(mem_en[3]),   32'(c == 1));
      check($sformatf("post_if_valid_c%0d", c), 32'(if_valid[3]), 32'(c == 6));
      check($sformatf("post_stall_c%0d", c),    32'(stall[3]),    32'(c <= 5));
      if (mem_en[3]) check("post_mem_addr", mem_addr[3], B_ADDR);
      if (if_valid[3]) pop_check("post_if_rdata", if_rdata[3]);
      cyc();
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
